instruction_fetch_buffer: RTL and testbench

INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

---
 rtl/instruction_fetch_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_instruction_fetch_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: a DEPTH x INS_LEN instruction store that is loaded
// and inspected beat-wise over a simple AXI-style port, and streamed out
// sequentially through a 2-entry valid/ready FIFO by a small fetch FSM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   axi_icache_*        beat-addressed store access (write / 1-cycle read)
//   fetch_start/pc/count/abort  fetch control
//   fetch_busy          fetch in progress (RUN or DRAIN)
//   fetch_done          one-cycle pulse on normal completion
//   ins_valid/ready/data/pc     instruction stream, FIFO head
module instruction_fetch_buffer #(
  parameter int unsigned INS_LEN = 54,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned AXI_DW  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       axi_icache_en,
  input  logic                       axi_icache_we,
  input  logic [15:0]                axi_icache_addr,
  input  logic [AXI_DW-1:0]          axi_icache_wdata,
  output logic [AXI_DW-1:0]          axi_icache_rdata,
  input  logic                       fetch_start,
  input  logic [$clog2(DEPTH)-1:0]   fetch_pc,
  input  logic [$clog2(DEPTH):0]     fetch_count,
  input  logic                       fetch_abort,
  output logic                       fetch_busy,
  output logic                       fetch_done,
  output logic                       ins_valid,
  input  logic                       ins_ready,
  output logic [INS_LEN-1:0]         ins_data,
  output logic [$clog2(DEPTH)-1:0]   ins_pc
);

  localparam int unsigned AW        = 16;
  localparam int unsigned BEATS     = (INS_LEN + AXI_DW - 1) / AXI_DW;
  localparam int unsigned BB        = (BEATS > 1) ? $clog2(BEATS) : 0;
  localparam int unsigned BIW       = (BB > 0) ? BB : 1;
  localparam int unsigned BEAT_SPAN = 1 << BB;
  localparam int unsigned RW        = $clog2(DEPTH);
  localparam int unsigned PW        = BEATS * AXI_DW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef logic [BEATS-1:0][AXI_DW-1:0] row_t;

  // Bits at or above INS_LEN are not part of an instruction and always read as 0.
  localparam row_t ROW_MASK = row_t'({PW{1'b1}} >> (PW - INS_LEN));

  row_t mem [DEPTH];

  // AXI address decode
  logic [BIW-1:0] beat_c;
  logic [RW-1:0]  row_c;
  logic [AW-1:0]  upper_c;
  logic           addr_ok_c;
  logic           axi_wr_c;
  logic           axi_rd_c;
  row_t           axi_row_c;

  assign beat_c    = BIW'(axi_icache_addr & AW'(BEAT_SPAN - 1));
  assign row_c     = RW'(axi_icache_addr >> BB);
  assign upper_c   = axi_icache_addr >> (BB + RW);
  assign addr_ok_c = (32'(beat_c) < BEATS) && (upper_c == '0);
  assign axi_wr_c  = axi_icache_en && axi_icache_we && addr_ok_c;
  assign axi_rd_c  = axi_icache_en && !axi_icache_we && addr_ok_c;
  assign axi_row_c = mem[row_c] & ROW_MASK;

  // Storage: not reset; a same-cycle fetch read sees the pre-write row.
  always_ff @(posedge clk) begin
    if (axi_wr_c) begin
      mem[row_c][beat_c] <= axi_icache_wdata;
    end
  end

  // AXI read beat, zero whenever the previous cycle held no valid read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_icache_rdata <= '0;
    end else begin
      axi_icache_rdata <= axi_rd_c ? axi_row_c[beat_c] : '0;
    end
  end

  // Fetch state, 2-entry output FIFO (head drives the outputs directly)
  logic [1:0]         state, state_n;
  logic [RW-1:0]      pc, pc_n;
  logic [RW:0]        remaining, remaining_n;
  logic               head_v, head_v_n, tail_v, tail_v_n;
  logic [INS_LEN-1:0] head_d, head_d_n, tail_d, tail_d_n;
  logic [RW-1:0]      head_pc, head_pc_n, tail_pc, tail_pc_n;
  logic               busy_n, done_n;
  logic [INS_LEN-1:0] fetch_row_c;
  logic               pop_c;
  logic               issue_c;

  assign fetch_row_c = INS_LEN'(mem[pc]);
  assign pop_c       = head_v && ins_ready;
  // The read lands in the FIFO at the edge closing its issue cycle, so the
  // only thing to guard is a full FIFO that is not draining this cycle.
  assign issue_c     = (state == RUN) && !fetch_abort && !(tail_v && !pop_c);

  assign ins_valid = head_v;
  assign ins_data  = head_d;
  assign ins_pc    = head_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      remaining  <= '0;
      head_v     <= 1'b0;
      tail_v     <= 1'b0;
      head_d     <= '0;
      tail_d     <= '0;
      head_pc    <= '0;
      tail_pc    <= '0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      remaining  <= remaining_n;
      head_v     <= head_v_n;
      tail_v     <= tail_v_n;
      head_d     <= head_d_n;
      tail_d     <= tail_d_n;
      head_pc    <= head_pc_n;
      tail_pc    <= tail_pc_n;
      fetch_busy <= busy_n;
      fetch_done <= done_n;
    end
  end

  // Next-state, FIFO update and registered output values
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    remaining_n = remaining;
    done_n      = 1'b0;
    head_v_n    = head_v;
    tail_v_n    = tail_v;
    head_d_n    = head_d;
    tail_d_n    = tail_d;
    head_pc_n   = head_pc;
    tail_pc_n   = tail_pc;

    case (state)
      IDLE: begin
        if (fetch_start) begin
          if (fetch_count != '0) begin
            state_n     = RUN;
            pc_n        = fetch_pc;
            remaining_n = fetch_count;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue_c) begin
          pc_n        = pc + RW'(1);
          remaining_n = remaining - (RW+1)'(1);
          if (remaining == (RW+1)'(1)) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once this cycle's pop empties the FIFO.
        if (!tail_v && (!head_v || pop_c)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop_c) begin
      head_v_n  = tail_v;
      head_d_n  = tail_d;
      head_pc_n = tail_pc;
      tail_v_n  = 1'b0;
    end

    if (issue_c) begin
      if (!head_v_n) begin
        head_v_n  = 1'b1;
        head_d_n  = fetch_row_c;
        head_pc_n = pc;
      end else begin
        tail_v_n  = 1'b1;
        tail_d_n  = fetch_row_c;
        tail_pc_n = pc;
      end
    end

    // Abort beats everything, including a simultaneous start.
    if (fetch_abort) begin
      state_n  = IDLE;
      done_n   = 1'b0;
      head_v_n = 1'b0;
      tail_v_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer (INS_LEN=100, DEPTH=16,
// AXI_DW=64): a queue-based model checked every cycle plus literal vectors.
module tb_instruction_fetch_buffer;

  logic         clk;
  logic         rst_n;
  logic         axi_icache_en;
  logic         axi_icache_we;
  logic [15:0]  axi_icache_addr;
  logic [63:0]  axi_icache_wdata;
  logic [63:0]  axi_icache_rdata;
  logic         fetch_start;
  logic [3:0]   fetch_pc;
  logic [4:0]   fetch_count;
  logic         fetch_abort;
  logic         fetch_busy;
  logic         fetch_done;
  logic         ins_valid;
  logic         ins_ready;
  logic [99:0]  ins_data;
  logic [3:0]   ins_pc;

  instruction_fetch_buffer #(.INS_LEN(100), .DEPTH(16), .AXI_DW(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .axi_icache_en    (axi_icache_en),
    .axi_icache_we    (axi_icache_we),
    .axi_icache_addr  (axi_icache_addr),
    .axi_icache_wdata (axi_icache_wdata),
    .axi_icache_rdata (axi_icache_rdata),
    .fetch_start      (fetch_start),
    .fetch_pc         (fetch_pc),
    .fetch_count      (fetch_count),
    .fetch_abort      (fetch_abort),
    .fetch_busy       (fetch_busy),
    .fetch_done       (fetch_done),
    .ins_valid        (ins_valid),
    .ins_ready        (ins_ready),
    .ins_data         (ins_data),
    .ins_pc           (ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [3:0]  pc;
    logic [99:0] data;
  } exp_t;

  logic [99:0] mem_m [16];
  exp_t        exp_q[$];
  logic [63:0] rdata_exp = '0;
  logic        done_exp  = 1'b0;
  logic        busy_exp  = 1'b0;
  bit          active    = 1'b0;
  int          delivered = 0;

  always @(negedge clk) begin
    logic [127:0] full;
    logic [63:0]  rdata_nx;
    logic         done_nx;
    logic         busy_nx;
    bit           was_active;
    int           r;
    int           b;
    exp_t         e;
    if (!rst_n) begin
      check("rst_ins_valid", ins_valid, 0);
      check("rst_fetch_busy", fetch_busy, 0);
      check("rst_fetch_done", fetch_done, 0);
      check("rst_rdata", axi_icache_rdata, 0);
      exp_q.delete();
      rdata_exp = '0;
      done_exp  = 1'b0;
      busy_exp  = 1'b0;
      active    = 1'b0;
    end else begin
      check("axi_rdata", axi_icache_rdata, rdata_exp);
      check("fetch_done", fetch_done, done_exp);
      check("fetch_busy", fetch_busy, busy_exp);
      if (exp_q.size() == 0) begin
        check("ins_valid_empty", ins_valid, 0);
      end else if (ins_valid) begin
        check("ins_data", ins_data, exp_q[0].data);
        check("ins_pc", ins_pc, exp_q[0].pc);
      end

      was_active = active;
      done_nx    = 1'b0;
      busy_nx    = busy_exp;
      rdata_nx   = '0;
      if (fetch_abort) begin
        exp_q.delete();
        active  = 1'b0;
        busy_nx = 1'b0;
      end else if (ins_valid && ins_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
        if (exp_q.size() == 0) begin
          done_nx = 1'b1;
          busy_nx = 1'b0;
          active  = 1'b0;
        end
      end

      if (axi_icache_en && axi_icache_addr < 16'd32) begin
        r    = int'(axi_icache_addr) / 2;
        b    = int'(axi_icache_addr) % 2;
        full = 128'(mem_m[r]);
        if (axi_icache_we) begin
          full[b*64 +: 64] = axi_icache_wdata;
          mem_m[r] = full[99:0];
        end else begin
          rdata_nx = full[b*64 +: 64];
        end
      end

      if (fetch_start && !was_active && !fetch_abort) begin
        if (fetch_count == 0) begin
          done_nx = 1'b1;
        end else begin
          for (int i = 0; i < int'(fetch_count); i++) begin
            e.pc   = 4'((int'(fetch_pc) + i) % 16);
            e.data = mem_m[e.pc];
            exp_q.push_back(e);
          end
          active  = 1'b1;
          busy_nx = 1'b1;
        end
      end

      rdata_exp = rdata_nx;
      done_exp  = done_nx;
      busy_exp  = busy_nx;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [63:0] d);
    axi_icache_en = 1'b1; axi_icache_we = 1'b1;
    axi_icache_addr = a; axi_icache_wdata = d;
    tick();
    axi_icache_en = 1'b0; axi_icache_we = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a);
    axi_icache_en = 1'b1; axi_icache_we = 1'b0; axi_icache_addr = a;
    tick();
    axi_icache_en = 1'b0;
  endtask

  task automatic start(input logic [3:0] pc, input logic [4:0] cnt);
    fetch_start = 1'b1; fetch_pc = pc; fetch_count = cnt;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((active || exp_q.size() != 0 || done_exp) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  initial begin
    int wrap_pc [4] = '{14, 15, 0, 1};
    int base;
    int n;

    rst_n = 1'b0;
    axi_icache_en = 1'b0; axi_icache_we = 1'b0;
    axi_icache_addr = '0; axi_icache_wdata = '0;
    fetch_start = 1'b0; fetch_pc = '0; fetch_count = '0;
    fetch_abort = 1'b0; ins_ready = 1'b1;
    tick();
    check("reset_ins_valid", ins_valid, 0);
    check("reset_busy", fetch_busy, 0);
    check("reset_done", fetch_done, 0);
    check("reset_ins_data", ins_data, 0);
    check("reset_ins_pc", ins_pc, 0);
    check("reset_rdata", axi_icache_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Rows 0..7 hold 10..17; rows 8..15 also carry high-beat bits.
    for (int i = 0; i < 16; i++) begin
      axi_write(16'(2*i), 64'(10 + i));
      axi_write(16'(2*i + 1), (i < 8) ? 64'd0 : (64'h0000_000F_0000_0000 | 64'(i)));
    end

    // Sequential fetch, ready held high
    start(4'd2, 5'd4);
    check("seq_c1_valid", ins_valid, 0);
    check("seq_c1_busy", fetch_busy, 1);
    tick(); check("seq_d0", ins_data, 100'd12); check("seq_p0", ins_pc, 2);
    tick(); check("seq_d1", ins_data, 100'd13); check("seq_p1", ins_pc, 3);
    tick(); check("seq_d2", ins_data, 100'd14); check("seq_p2", ins_pc, 4);
    tick(); check("seq_d3", ins_data, 100'd15); check("seq_p3", ins_pc, 5);
    tick(); check("seq_done", fetch_done, 1); check("seq_valid_end", ins_valid, 0);
    tick(); check("seq_done_pulse", fetch_done, 0);
    wait_idle(20);

    // Wrap at DEPTH
    start(4'd14, 5'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_pc", ins_pc, 128'(wrap_pc[k]));
    end
    wait_idle(20);

    // Beat writes, truncation and read-back
    axi_write(16'd6, 64'hAAAA_BBBB_CCCC_DDDD);
    axi_write(16'd7, 64'h0000_000F_1234_5678);
    axi_read(16'd7);
    check("axi_rd7", axi_icache_rdata, 64'h0000_000F_1234_5678);
    tick();
    check("axi_rd_idle", axi_icache_rdata, 0);
    axi_write(16'd19, 64'hDEAD_BEEF_0000_0001);
    axi_read(16'd19);
    check("axi_trunc", axi_icache_rdata, 64'h0000_000F_0000_0001);
    axi_write(16'd38, 64'h1111_1111_1111_1111);
    axi_read(16'd38);
    check("axi_oor_rd", axi_icache_rdata, 0);
    axi_read(16'd6);
    check("axi_oor_wr_ignored", axi_icache_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    start(4'd3, 5'd1);
    tick();
    check("row3_data", ins_data, {36'hF_1234_5678, 64'hAAAA_BBBB_CCCC_DDDD});
    check("row3_pc", ins_pc, 3);
    wait_idle(20);

    // Full-depth fetch with random backpressure
    base = delivered;
    ins_ready = 1'b0;
    start(4'd0, 5'd16);
    n = 0;
    while (delivered - base < 16 && n < 400) begin
      ins_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ins_ready = 1'b1;
    check("rand_delivered", delivered - base, 16);
    wait_idle(20);

    // Start while busy is ignored
    start(4'd4, 5'd3);
    fetch_start = 1'b1; fetch_pc = 4'd9; fetch_count = 5'd2;
    tick();
    fetch_start = 1'b0;
    wait_idle(20);

    // Abort after two transfers
    start(4'd0, 5'd8);
    tick(); tick(); tick();
    fetch_abort = 1'b1; ins_ready = 1'b0;
    tick();
    check("abort_valid", ins_valid, 0);
    check("abort_busy", fetch_busy, 0);
    check("abort_done", fetch_done, 0);
    fetch_abort = 1'b0; ins_ready = 1'b1;
    tick();
    check("abort_no_done", fetch_done, 0);
    start(4'd0, 5'd1);
    tick();
    check("post_abort_data", ins_data, 100'd10);
    wait_idle(20);

    // Abort beats a simultaneous start
    fetch_start = 1'b1; fetch_pc = 4'd1; fetch_count = 5'd3; fetch_abort = 1'b1;
    tick();
    fetch_start = 1'b0; fetch_abort = 1'b0;
    tick();
    check("abort_start_busy", fetch_busy, 0);
    check("abort_start_valid", ins_valid, 0);
    wait_idle(5);

    // Zero-length fetch
    start(4'd5, 5'd0);
    check("zero_done", fetch_done, 1);
    check("zero_busy", fetch_busy, 0);
    check("zero_valid", ins_valid, 0);
    tick();
    check("zero_done_pulse", fetch_done, 0);
    wait_idle(5);

    // Same-row write during the fetch read returns the old row
    start(4'd5, 5'd1);
    axi_write(16'd10, 64'h5555);
    check("conflict_old", ins_data, 100'd15);
    wait_idle(20);
    axi_read(16'd10);
    check("conflict_new", axi_icache_rdata, 64'h5555);

    // Reset in the middle of a stalled fetch
    ins_ready = 1'b0;
    start(4'd0, 5'd4);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", ins_valid, 0);
    check("midrst_busy", fetch_busy, 0);
    check("midrst_done", fetch_done, 0);
    check("midrst_data", ins_data, 0);
    check("midrst_pc", ins_pc, 0);
    check("midrst_rdata", axi_icache_rdata, 0);
    tick();
    rst_n = 1'b1;
    ins_ready = 1'b1;
    tick();
    start(4'd2, 5'd1);
    tick();
    check("retained_row2", ins_data, 100'd12);
    wait_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
